rebote_multicanal: RTL and testbench

Parametrised multi-channel push-button debouncer. It is the successor to the single-channel two-sample edge detector. It synchronises N asynchronous button inputs, samples them on a shared prescaled tick, and accepts a new level only after N_MUESTRAS consecutive equal samples. Per channel it outputs the clean level, one-cycle rising and falling pulses, and an optional auto-repeat pulse for held buttons. It sits between the board push-buttons and the control FSMs.

---
 rtl/rebote_multicanal.sv | 126 ++++++++++++
 tb/tb_rebote_multicanal.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rebote_multicanal.sv
// rtl/rebote_multicanal.sv - multi-channel push-button debouncer with edge and auto-repeat pulses
//
// Ports:
//   reloj       system clock, rising edge
//   resetM      synchronous active-high reset
//   pb_in       raw asynchronous button levels, active-high
//   pb_estable  debounced level
//   pb_subida   one-cycle pulse on debounced 0->1
//   pb_bajada   one-cycle pulse on debounced 1->0
//   pb_repite   one-cycle auto-repeat pulse while held (REPETIR=1 only)

module rebote_multicanal #(
   parameter int N_CANALES   = 4,
   parameter int DIV_TICK    = 20000,
   parameter int N_MUESTRAS  = 4,
   parameter int REPETIR     = 0,
   parameter int RETARDO_REP = 50,
   parameter int PERIODO_REP = 10
) (
   input  logic                 reloj,
   input  logic                 resetM,
   input  logic [N_CANALES-1:0] pb_in,
   output logic [N_CANALES-1:0] pb_estable,
   output logic [N_CANALES-1:0] pb_subida,
   output logic [N_CANALES-1:0] pb_bajada,
   output logic [N_CANALES-1:0] pb_repite
);

   localparam int DIV_W   = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
   localparam int CNT_W   = $clog2(N_MUESTRAS) + 1;
   localparam int REP_MAX = (RETARDO_REP > PERIODO_REP) ? RETARDO_REP : PERIODO_REP;
   localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

   localparam logic [DIV_W-1:0] DIV_ULT = DIV_W'(DIV_TICK - 1);
   localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(N_MUESTRAS - 1);
   localparam logic [REP_W-1:0] LIM_RET = REP_W'(RETARDO_REP - 1);
   localparam logic [REP_W-1:0] LIM_PER = REP_W'(PERIODO_REP - 1);

   logic [N_CANALES-1:0] s1_q, s1_d;
   logic [N_CANALES-1:0] s2_q, s2_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [CNT_W-1:0]     cnt_q [N_CANALES];
   logic [CNT_W-1:0]     cnt_d [N_CANALES];
   logic [N_CANALES-1:0] estable_q, estable_d;
   logic [N_CANALES-1:0] hist_q, hist_d;
   logic [REP_W-1:0]     rep_q [N_CANALES];
   logic [REP_W-1:0]     rep_d [N_CANALES];
   logic [N_CANALES-1:0] primero_q, primero_d;
   logic [N_CANALES-1:0] repite_q, repite_d;
   logic                 tick;

   // With DIV_TICK=1 the counter sits at 0 and tick is permanently high.
   assign tick = (div_q == DIV_ULT);

   always_comb begin
      s1_d      = pb_in;
      s2_d      = s1_q;
      div_d     = tick ? '0 : div_q + DIV_W'(1);
      hist_d    = estable_q;
      estable_d = estable_q;
      cnt_d     = cnt_q;
      rep_d     = rep_q;
      primero_d = primero_q;
      repite_d  = '0;

      for (int i = 0; i < N_CANALES; i++) begin
         // Any agreeing sample restarts the count, so only an unbroken
         // run of N_MUESTRAS disagreeing ticks flips the clean level.
         if (tick) begin
            if (s2_q[i] == estable_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_ULT) begin
               estable_d[i] = s2_q[i];
               cnt_d[i]     = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end

         // Repeat timer uses the registered level, so the tick that
         // flips the level to 1 still sees 0 and does not count.
         if (!estable_q[i]) begin
            rep_d[i]     = '0;
            primero_d[i] = 1'b1;
         end else if (tick) begin
            if (rep_q[i] == (primero_q[i] ? LIM_RET : LIM_PER)) begin
               repite_d[i]  = 1'b1;
               rep_d[i]     = '0;
               primero_d[i] = 1'b0;
            end else begin
               rep_d[i] = rep_q[i] + REP_W'(1);
            end
         end
      end
   end

   always_ff @(posedge reloj) begin
      if (resetM) begin
         s1_q      <= '0;
         s2_q      <= '0;
         div_q     <= '0;
         cnt_q     <= '{default: '0};
         estable_q <= '0;
         hist_q    <= '0;
         rep_q     <= '{default: '0};
         primero_q <= '0;
         repite_q  <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         estable_q <= estable_d;
         hist_q    <= hist_d;
         rep_q     <= rep_d;
         primero_q <= primero_d;
         repite_q  <= repite_d;
      end
   end

   assign pb_estable = estable_q;
   assign pb_subida  = estable_q & ~hist_q;
   assign pb_bajada  = ~estable_q & hist_q;
   assign pb_repite  = (REPETIR != 0) ? repite_q : '0;

endmodule

// File: tb/tb_rebote_multicanal.sv
// tb/tb_rebote_multicanal.sv - directed self-checking bench for rebote_multicanal

module tb_rebote_multicanal;

   logic reloj = 1'b0;
   always #5 reloj = ~reloj;

   logic       resetM;
   logic [3:0] pb_a, est_a, sub_a, baj_a, rep_a;
   logic [0:0] pb_b, est_b, sub_b, baj_b, rep_b;

   int n_asserts = 0;
   int n_fails   = 0;

   rebote_multicanal #(
      .N_CANALES(4), .DIV_TICK(1), .N_MUESTRAS(4),
      .REPETIR(1), .RETARDO_REP(3), .PERIODO_REP(2)
   ) dut_a (
      .reloj(reloj), .resetM(resetM), .pb_in(pb_a),
      .pb_estable(est_a), .pb_subida(sub_a), .pb_bajada(baj_a), .pb_repite(rep_a)
   );

   rebote_multicanal #(
      .N_CANALES(1), .DIV_TICK(5), .N_MUESTRAS(3),
      .REPETIR(0), .RETARDO_REP(3), .PERIODO_REP(2)
   ) dut_b (
      .reloj(reloj), .resetM(resetM), .pb_in(pb_b),
      .pb_estable(est_b), .pb_subida(sub_b), .pb_bajada(baj_b), .pb_repite(rep_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_asserts++;
      if (obs !== exp_v) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_a(input string t, input int k,
                          input logic [3:0] e_est, input logic [3:0] e_sub,
                          input logic [3:0] e_baj);
      check_eq($sformatf("%s est k=%0d", t, k), 32'(est_a), 32'(e_est));
      check_eq($sformatf("%s sub k=%0d", t, k), 32'(sub_a), 32'(e_sub));
      check_eq($sformatf("%s baj k=%0d", t, k), 32'(baj_a), 32'(e_baj));
   endtask

   initial begin
      bit pat [6];
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      resetM = 1'b1;
      pb_a   = 4'b0000;
      pb_b   = 1'b0;
      repeat (3) @(negedge reloj);

      check_eq("reset est_a", 32'(est_a), 32'h0);
      check_eq("reset sub_a", 32'(sub_a), 32'h0);
      check_eq("reset baj_a", 32'(baj_a), 32'h0);
      check_eq("reset rep_a", 32'(rep_a), 32'h0);
      check_eq("reset est_b", 32'(est_b), 32'h0);
      check_eq("reset sub_b", 32'(sub_b), 32'h0);
      check_eq("reset baj_b", 32'(baj_b), 32'h0);
      check_eq("reset rep_b", 32'(rep_b), 32'h0);

      // Prescaled channel: press straight out of reset, ticks fall on every 5th edge.
      resetM = 1'b0;
      pb_b   = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge reloj);
         check_eq($sformatf("pre est_b k=%0d", k), 32'(est_b), (k >= 15 && k < 35) ? 32'h1 : 32'h0);
         check_eq($sformatf("pre sub_b k=%0d", k), 32'(sub_b), (k == 15) ? 32'h1 : 32'h0);
         check_eq($sformatf("pre baj_b k=%0d", k), 32'(baj_b), (k == 35) ? 32'h1 : 32'h0);
         check_eq($sformatf("pre rep_b k=%0d", k), 32'(rep_b), 32'h0);
         if (k == 20) pb_b = 1'b0;
      end

      // Clean press, auto-repeat and release on channel 0.
      pb_a = 4'b0001;
      for (int k = 1; k <= 30; k++) begin
         @(negedge reloj);
         check_a("press", k,
                 (k >= 6 && k < 24) ? 4'b0001 : 4'b0000,
                 (k == 6)  ? 4'b0001 : 4'b0000,
                 (k == 24) ? 4'b0001 : 4'b0000);
         check_eq($sformatf("press rep k=%0d", k), 32'(rep_a),
                  (k >= 9 && k <= 23 && (k % 2) == 1) ? 32'h1 : 32'h0);
         if (k == 18) pb_a = 4'b0000;
      end

      // Bounce on channel 1: 1,1,0,1,1,0 then steady 1.
      pb_a = {2'b00, pat[0], 1'b0};
      for (int k = 1; k <= 16; k++) begin
         @(negedge reloj);
         check_a("bounce", k,
                 (k >= 12) ? 4'b0010 : 4'b0000,
                 (k == 12) ? 4'b0010 : 4'b0000,
                 4'b0000);
         pb_a = {2'b00, (k < 6) ? pat[k] : 1'b1, 1'b0};
      end
      pb_a = 4'b0000;
      repeat (12) @(negedge reloj);
      check_eq("bounce released est", 32'(est_a), 32'h0);

      // Simultaneous transitions across channels.
      pb_a = 4'b0101;
      for (int k = 1; k <= 18; k++) begin
         @(negedge reloj);
         check_a("multi", k,
                 (k < 6) ? 4'b0000 : ((k < 16) ? 4'b0101 : 4'b0110),
                 (k == 6) ? 4'b0101 : ((k == 16) ? 4'b0010 : 4'b0000),
                 (k == 16) ? 4'b0001 : 4'b0000);
         if (k == 10) pb_a = 4'b0110;
      end

      // Reset one edge before channel 3's first repeat pulse.
      pb_a = 4'b1000;
      for (int k = 1; k <= 8; k++) begin
         @(negedge reloj);
      end
      check_eq("pre-reset est", 32'(est_a), 32'h8);
      check_eq("pre-reset rep", 32'(rep_a), 32'h0);
      resetM = 1'b1;
      @(negedge reloj);
      check_eq("mid-reset est", 32'(est_a), 32'h0);
      check_eq("mid-reset sub", 32'(sub_a), 32'h0);
      check_eq("mid-reset baj", 32'(baj_a), 32'h0);
      check_eq("mid-reset rep", 32'(rep_a), 32'h0);
      resetM = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge reloj);
         check_a("redebounce", k,
                 (k >= 6) ? 4'b1000 : 4'b0000,
                 (k == 6) ? 4'b1000 : 4'b0000,
                 4'b0000);
         check_eq($sformatf("redebounce rep k=%0d", k), 32'(rep_a), (k == 9) ? 32'h8 : 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
